hazard_stall_ctrl: RTL and testbench

//  Consumer-side hazard controller for the ID/EX pipeline register: reads the EX-stage fields and issues stall/flush controls.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_loaduse_cmp.sv | 17 +
 rtl/hazard_stall_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Combinational load-use detector: a load in EX whose destination feeds a source of the ID instruction.
module hazard_loaduse_cmp
  import hazard_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       lu
);

  // $zero is never a real dependency, so a load targeting r0 cannot cause a stall.
  assign lu = idex_mem_read && (idex_rt != REG_ZERO) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller between IF/ID and ID/EX: load-use stalls, branch/jump flushes, data-memory waits.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_events performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_MEM_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  input  logic        jump_id,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [2:0]            FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = WAIT_CNT_W'(MAX_MEM_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_SAT   = '1;

  hz_state_t             state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [2:0]            flush_cnt, flush_cnt_next;
  logic                  timeout_q;
  logic                  lu;
  logic                  mem_pending;
  logic                  eval_run;
  logic                  flush_event;

  hazard_loaduse_cmp u_lu_cmp (
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .lu            (lu)
  );

  assign mem_pending = dmem_req && !dmem_ready;
  assign mem_timeout = timeout_q;
  assign state_o     = state;

  // MEM_WAIT releasing on dmem_ready behaves exactly like RUN for that cycle, hence the shared eval_run path.
  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pipe_hold      = 1'b0;
    flush_event    = 1'b0;
    eval_run       = 1'b0;
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    flush_cnt_next = flush_cnt;

    case (state)
      RUN: eval_run = 1'b1;
      FLUSH: begin
        if (mem_pending) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          pipe_hold      = 1'b1;
          state_next     = MEM_WAIT;
          wait_cnt_next  = WAIT_CNT_W'(1);
          flush_cnt_next = 3'd0;
        end else begin
          ifid_flush = 1'b1;
          if (flush_cnt <= 3'd1) begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
          end else begin
            flush_cnt_next = flush_cnt - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (wait_cnt != WAIT_SAT) wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
        end else begin
          eval_run = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (eval_run) begin
      state_next     = RUN;
      wait_cnt_next  = '0;
      flush_cnt_next = 3'd0;
      if (mem_pending) begin
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        pipe_hold     = 1'b1;
        state_next    = MEM_WAIT;
        wait_cnt_next = WAIT_CNT_W'(1);
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_event = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_INIT;
        end
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (jump_id) begin
        ifid_flush  = 1'b1;
        flush_event = 1'b1;
      end
    end

    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      flush_event = 1'b0;
    end
  end

  // Timeout latches on the edge where the wait count reaches the limit, so it is visible while wait_cnt==MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      flush_cnt <= flush_cnt_next;
      if (wait_cnt_next == WAIT_MAX) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_write)   stall_cycles <= stall_cycles + 32'd1;
      if (flush_event) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven scoreboard bench for hazard_stall_ctrl (FLUSH_CYCLES=2 main instance, FLUSH_CYCLES=1 side instance).
module tb_hazard_stall_ctrl;

  typedef struct {
    string      name;
    logic       chk;
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] idex_rt;
    logic       branch;
    logic       jump;
    logic       req;
    logic       ready;
    logic [7:0] exp;
    logic       chk1;
    logic       exp_flush1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic ifid_uses_rt, idex_mem_read, branch_taken, jump_id, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [1:0] state_o;
  logic pc_write1, ifid_write1, ifid_flush1, idex_bubble1, pipe_hold1, mem_timeout1;
  logic [1:0] state_o1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, stall_cycles1, flush_events1;
  int model_stall = 0;
  int model_flush = 0;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_MEM_WAIT(8)) u_dut (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken), .jump_id(jump_id),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  hazard_stall_ctrl #(.FLUSH_CYCLES(1), .MAX_MEM_WAIT(8)) u_dut1 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken), .jump_id(jump_id),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write1), .ifid_write(ifid_write1),
    .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .pipe_hold(pipe_hold1),
    .mem_timeout(mem_timeout1), .state_o(state_o1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles1), .flush_events(flush_events1)
`endif
  );

  // Expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout, state_o}.
  function automatic logic [7:0] E(logic pc, logic iw, logic fl, logic bb, logic ph, logic to, logic [1:0] st);
    return {pc, iw, fl, bb, ph, to, st};
  endfunction

  function automatic vec_t mk(string name, logic r, logic [4:0] rs, logic [4:0] rt, logic ur, logic mr,
                              logic [4:0] irt, logic br, logic jp, logic rq, logic rdy, logic [7:0] exp);
    vec_t v;
    v.name = name; v.chk = 1'b1; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.mem_read = mr;
    v.idex_rt = irt; v.branch = br; v.jump = jp; v.req = rq; v.ready = rdy; v.exp = exp;
    v.chk1 = 1'b0; v.exp_flush1 = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt; idex_mem_read = v.mem_read;
    idex_rt = v.idex_rt; branch_taken = v.branch; jump_id = v.jump; dmem_req = v.req; dmem_ready = v.ready;
    sb_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    logic [7:0] act;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    v = sb_q.pop_front();
    act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout, state_o};
    if (v.chk) begin
      checks++;
      if (act !== v.exp) begin
        errors++;
        $display("[TB] FAIL %s: got pc/iw/fl/bb/ph/to/st=%b/%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%b/%0d",
                 v.name, act[7], act[6], act[5], act[4], act[3], act[2], act[1:0],
                 v.exp[7], v.exp[6], v.exp[5], v.exp[4], v.exp[3], v.exp[2], v.exp[1:0]);
      end
    end
    if (v.chk1) begin
      checks++;
      if (ifid_flush1 !== v.exp_flush1) begin
        errors++;
        $display("[TB] FAIL %s_fc1: got ifid_flush=%b required %b", v.name, ifid_flush1, v.exp_flush1);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'(model_stall) || flush_events !== 32'(model_flush)) begin
      errors++;
      $display("[TB] FAIL %s_perf: got stall=%0d flush=%0d required stall=%0d flush=%0d",
               v.name, stall_cycles, flush_events, model_stall, model_flush);
    end
    if (v.rst) begin
      model_stall = 0;
      model_flush = 0;
    end else begin
      if (!v.exp[7]) model_stall++;
      if (v.exp[5] && v.exp[1:0] != 2'd1) model_flush++;
    end
`endif
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; idex_rt = '0;
    branch_taken = 1'b0; jump_id = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);

    //                name            rst rs  rt  ur mr irt br jp rq rdy  expected
    vecs.push_back(mk("reset",          1, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("idle",           0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("lu_rs",          0, 8,  1,  1, 1, 8,  0, 0, 0, 0, E(0,0,0,1,0,0,0)));
    vecs.push_back(mk("lu_after",       0, 8,  1,  1, 0, 8,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("lu_rt",          0, 3,  9,  1, 1, 9,  0, 0, 0, 0, E(0,0,0,1,0,0,0)));
    vecs.push_back(mk("lu_r0",          0, 0,  0,  1, 1, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("lu_rt_unused",   0, 4,  9,  0, 1, 9,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("jump",           0, 4,  5,  0, 0, 9,  0, 1, 0, 0, E(1,1,1,0,0,0,0)));
    vecs.push_back(mk("jump_lu",        0, 8,  5,  0, 1, 8,  0, 1, 0, 0, E(0,0,0,1,0,0,0)));
    vecs.push_back(mk("jump_retry",     0, 8,  5,  0, 0, 8,  0, 1, 0, 0, E(1,1,1,0,0,0,0)));
    v = mk("br_lu",                     0, 8,  5,  0, 1, 8,  1, 0, 0, 0, E(1,1,1,1,0,0,0));
    v.chk1 = 1'b1; v.exp_flush1 = 1'b1; vecs.push_back(v);
    v = mk("flush2",                    0, 8,  5,  0, 1, 8,  0, 0, 0, 0, E(1,1,1,0,0,0,1));
    v.chk1 = 1'b1; v.exp_flush1 = 1'b0; vecs.push_back(v);
    vecs.push_back(mk("after_flush",    0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("br_memwait",     0, 0,  0,  0, 0, 0,  1, 0, 1, 0, E(0,0,0,0,1,0,0)));
    vecs.push_back(mk("wait1_supp",     0, 8,  0,  0, 1, 8,  1, 0, 1, 0, E(0,0,0,0,1,0,2)));
    vecs.push_back(mk("wait2",          0, 0,  0,  0, 0, 0,  0, 0, 1, 0, E(0,0,0,0,1,0,2)));
    vecs.push_back(mk("release_br",     0, 0,  0,  0, 0, 0,  1, 0, 1, 1, E(1,1,1,1,0,0,2)));
    vecs.push_back(mk("release_flush",  0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,1,0,0,0,1)));
    vecs.push_back(mk("idle2",          0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("br_again",       0, 0,  0,  0, 0, 0,  1, 0, 0, 0, E(1,1,1,1,0,0,0)));
    vecs.push_back(mk("flush_to_wait",  0, 0,  0,  0, 0, 0,  0, 0, 1, 0, E(0,0,0,0,1,0,1)));
    vecs.push_back(mk("wait_release",   0, 0,  0,  0, 0, 0,  0, 0, 1, 1, E(1,1,0,0,0,0,2)));
    vecs.push_back(mk("flush_dropped",  0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("wait_enter",     0, 0,  0,  0, 0, 0,  0, 0, 1, 0, E(0,0,0,0,1,0,0)));
    vecs.push_back(mk("rst_in_wait",    1, 0,  0,  0, 0, 0,  0, 0, 1, 0, E(1,1,0,0,0,0,2)));
    vecs.push_back(mk("post_rst_wait",  0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));
    vecs.push_back(mk("br_pre_rst",     0, 0,  0,  0, 0, 0,  1, 0, 0, 0, E(1,1,1,1,0,0,0)));
    vecs.push_back(mk("rst_in_flush",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,1)));
    vecs.push_back(mk("post_rst_flush", 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, E(1,1,0,0,0,0,0)));

    // Long data-memory wait: timeout becomes visible once MAX_MEM_WAIT wait cycles have been counted.
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk($sformatf("timeout_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                        E(0, 0, 0, 0, 1, (i >= 8), (i == 0) ? 2'd0 : 2'd2)));
    end
    vecs.push_back(mk("timeout_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E(1,1,0,0,0,1,2)));
    vecs.push_back(mk("timeout_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,1,0)));
    v = mk("timeout_rst",                1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,0));
    v.chk = 1'b0; vecs.push_back(v);
    vecs.push_back(mk("timeout_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,0)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
